gf180mcu_fd_sc_mcu9t5v0__aoi221_rb: RTL and testbench

Parametrised registered AOI221 bank: WIDTH independent AOI221 channels (ZN = !((A1&A2)|(B1&B2)|C)) feeding an output register with clock enable, a scan chain and a built-in exhaustive self-test (BIST). It is the sequential successor to the single-bit combinational AOI221 cell in the 9-track 5 V library, and serves as a macro for datapath control logic that needs registered, scan-testable AOI outputs.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__aoi221_rb_pkg.sv | 22 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__aoi221_rb_bist.sv | 88 ++++++++
 rtl/gf180mcu_fd_sc_mcu9t5v0__aoi221_rb.sv | 78 +++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__aoi221_rb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi221_rb_pkg.sv
// Shared types and constants for the registered AOI221 bank and its self-test.
package gf180mcu_fd_sc_mcu9t5v0__aoi221_rb_pkg;

   typedef enum logic [1:0] {
      BIST_IDLE,
      BIST_RUN,
      BIST_CHECK,
      BIST_DONE
   } bist_state_e;

   // One self-test vector drives {A1,A2,B1,B2,C}; all 32 combinations are walked.
   localparam int VEC_W   = 5;
   localparam int NUM_VEC = 32;

   // Golden single-channel AOI221 function.
   function automatic logic aoi221_f(input logic a1, input logic a2,
                                     input logic b1, input logic b2,
                                     input logic c);
      return ~((a1 & a2) | (b1 & b2) | c);
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi221_rb_bist.sv
// Exhaustive self-test controller: walks all AOI221 input combinations,
// keeps the expected result one cycle behind and compares it against ZN.
module gf180mcu_fd_sc_mcu9t5v0__aoi221_rb_bist
   import gf180mcu_fd_sc_mcu9t5v0__aoi221_rb_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             fi_i,
   input  logic [WIDTH-1:0] zn_i,
   output logic             start_ok_o,
   output logic             busy_o,
   output logic             run_o,
   output logic [VEC_W-1:0] vec_o,
   output logic             done_o,
   output logic             pass_o
);

   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

   bist_state_e      state_q, state_d;
   logic [VEC_W-1:0] cnt_q, cnt_d;
   logic             exp_q, exp_d;
   logic             fail_q, fail_d;
   logic [WIDTH-1:0] zn_chk;
   logic             mismatch;
   logic             cmp_en;

   // Fault injection flips channel 0 so the compare path itself is exercised.
   always_comb begin
      zn_chk    = zn_i;
      zn_chk[0] = zn_i[0] ^ fi_i;
   end

   // ZN lags the counter by one cycle, so vector 0 has no result to compare yet.
   assign cmp_en   = ((state_q == BIST_RUN) && (cnt_q != '0)) || (state_q == BIST_CHECK);
   assign mismatch = (zn_chk != {WIDTH{exp_q}});

   // Next-state, vector counter, expected-value pipe and sticky fail flag.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      fail_d  = fail_q;
      if (cmp_en && mismatch) fail_d = 1'b1;
      case (state_q)
         BIST_IDLE, BIST_DONE: begin
            if (start_i) begin
               state_d = BIST_RUN;
               cnt_d   = '0;
               fail_d  = 1'b0;
            end
         end
         BIST_RUN: begin
            exp_d = aoi221_f(cnt_q[4], cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_VEC) state_d = BIST_CHECK;
         end
         BIST_CHECK: state_d = BIST_DONE;
         default:    state_d = BIST_IDLE;
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= BIST_IDLE;
         cnt_q   <= '0;
         exp_q   <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         fail_q  <= fail_d;
      end
   end

   assign start_ok_o = start_i && ((state_q == BIST_IDLE) || (state_q == BIST_DONE));
   assign busy_o     = (state_q == BIST_RUN) || (state_q == BIST_CHECK);
   assign run_o      = (state_q == BIST_RUN);
   assign vec_o      = cnt_q;
   assign done_o     = (state_q == BIST_DONE);
   assign pass_o     = (state_q == BIST_DONE) && !fail_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi221_rb.sv
// Registered AOI221 bank with clock enable, scan chain and built-in self-test.
module gf180mcu_fd_sc_mcu9t5v0__aoi221_rb
   import gf180mcu_fd_sc_mcu9t5v0__aoi221_rb_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] A1,
   input  logic [WIDTH-1:0] A2,
   input  logic [WIDTH-1:0] B1,
   input  logic [WIDTH-1:0] B2,
   input  logic [WIDTH-1:0] C,
   input  logic             EN,
   input  logic             SE,
   input  logic             SI,
   output logic             SO,
   output logic [WIDTH-1:0] ZN,
   input  logic             BIST_START,
   input  logic             BIST_FI,
   output logic             BIST_BUSY,
   output logic             BIST_DONE,
   output logic             BIST_PASS
);

   logic [WIDTH-1:0] zn_q, zn_d;
   logic [WIDTH-1:0] func_zn, bist_zn, shift_zn;
   logic [VEC_W-1:0] vec;
   logic             start_ok, busy, run;

   gf180mcu_fd_sc_mcu9t5v0__aoi221_rb_bist #(.WIDTH(WIDTH)) u_bist (
      .clk_i      (CLK),
      .rst_i      (RST),
      .start_i    (BIST_START),
      .fi_i       (BIST_FI),
      .zn_i       (zn_q),
      .start_ok_o (start_ok),
      .busy_o     (busy),
      .run_o      (run),
      .vec_o      (vec),
      .done_o     (BIST_DONE),
      .pass_o     (BIST_PASS)
   );

   // Per-channel AOI221 on the functional inputs and on the broadcast test vector.
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      assign func_zn[i] = aoi221_f(A1[i], A2[i], B1[i], B2[i], C[i]);
      assign bist_zn[i] = aoi221_f(vec[4], vec[3], vec[2], vec[1], vec[0]);
   end

   // Scan shifts toward the MSB; SI enters at bit 0.
   always_comb begin
      shift_zn[0] = SI;
      for (int i = 1; i < WIDTH; i++) shift_zn[i] = zn_q[i-1];
   end

   // Output register source: self-test owns ZN while busy; an accepted start
   // suppresses scan/load on its own edge.
   always_comb begin
      zn_d = zn_q;
      if (run)            zn_d = bist_zn;
      else if (busy)      zn_d = zn_q;
      else if (start_ok)  zn_d = zn_q;
      else if (SE)        zn_d = shift_zn;
      else if (EN)        zn_d = func_zn;
   end

   // Output register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) zn_q <= '0;
      else     zn_q <= zn_d;
   end

   assign ZN        = zn_q;
   assign SO        = zn_q[WIDTH-1];
   assign BIST_BUSY = busy;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__aoi221_rb.sv
// Self-checking bench: directed table, randomized functional/scan traffic
// against a behavioural model, and self-test sequences.
module tb_gf180mcu_fd_sc_mcu9t5v0__aoi221_rb;

   localparam int W = 4;

   logic         CLK = 1'b0;
   logic         RST;
   logic [W-1:0] A1, A2, B1, B2, C;
   logic         EN, SE, SI;
   logic         SO;
   logic [W-1:0] ZN;
   logic         BIST_START, BIST_FI;
   logic         BIST_BUSY, BIST_DONE, BIST_PASS;

   int checks = 0;
   int errors = 0;

   gf180mcu_fd_sc_mcu9t5v0__aoi221_rb #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST),
      .A1(A1), .A2(A2), .B1(B1), .B2(B2), .C(C),
      .EN(EN), .SE(SE), .SI(SI), .SO(SO), .ZN(ZN),
      .BIST_START(BIST_START), .BIST_FI(BIST_FI),
      .BIST_BUSY(BIST_BUSY), .BIST_DONE(BIST_DONE), .BIST_PASS(BIST_PASS)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic         en, se, si;
      logic [W-1:0] a1, a2, b1, b2, c;
      logic [W-1:0] zn;
      logic         so;
   } vec_t;

   vec_t tbl[9];

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chk4(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %b expected %b", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_in(input logic en, input logic se, input logic si,
                         input logic [W-1:0] a1, input logic [W-1:0] a2,
                         input logic [W-1:0] b1, input logic [W-1:0] b2,
                         input logic [W-1:0] c);
      EN = en; SE = se; SI = si; A1 = a1; A2 = a2; B1 = b1; B2 = b2; C = c;
   endtask

   // Start a self-test and measure it. Optionally holds SE high on the start
   // edge (ZN must not move) and/or disturbs inputs while the run is busy.
   task automatic run_bist(input string tag, input logic fi, input logic exp_pass,
                           input logic disturb, input logic se_at_start,
                           input logic [W-1:0] zn_before);
      int n;
      BIST_FI    = fi;
      BIST_START = 1'b1;
      SE         = se_at_start;
      SI         = 1'b1;
      step();
      BIST_START = 1'b0;
      SE         = 1'b0;
      chk1({tag, "_done_cleared"}, BIST_DONE, 1'b0);
      if (se_at_start) chk4({tag, "_start_no_shift"}, ZN, zn_before);
      n = 0;
      while (BIST_BUSY === 1'b1 && n < 100) begin
         n++;
         if (disturb && n < 20) begin
            SE = 1'b1; SI = 1'b1; EN = 1'b1;
            BIST_START = (n % 3 == 0);
            A1 = 4'($urandom_range(0, 15)); C = 4'($urandom_range(0, 15));
         end else begin
            SE = 1'b0; EN = 1'b0; BIST_START = 1'b0;
         end
         step();
      end
      chki({tag, "_busy_cycles"}, n, 33);
      chk1({tag, "_done"}, BIST_DONE, 1'b1);
      chk1({tag, "_pass"}, BIST_PASS, exp_pass);
      chk4({tag, "_zn_after"}, ZN, 4'b0000);
      step();
      step();
      chk1({tag, "_done_held"}, BIST_DONE, 1'b1);
      BIST_FI = 1'b0;
   endtask

   initial begin
      int           mzn;
      int           nz;
      logic [W-1:0] zbefore;

      // Directed table: scan from reset, functional load, hold, SE priority over EN.
      tbl[0] = '{en:0, se:1, si:1, a1:0, a2:0, b1:0, b2:0, c:0, zn:4'b0001, so:0};
      tbl[1] = '{en:0, se:1, si:0, a1:0, a2:0, b1:0, b2:0, c:0, zn:4'b0010, so:0};
      tbl[2] = '{en:0, se:1, si:1, a1:0, a2:0, b1:0, b2:0, c:0, zn:4'b0101, so:0};
      tbl[3] = '{en:0, se:1, si:1, a1:0, a2:0, b1:0, b2:0, c:0, zn:4'b1011, so:1};
      tbl[4] = '{en:1, se:0, si:0, a1:4'b0011, a2:4'b0011, b1:0, b2:0, c:4'b0100, zn:4'b1000, so:1};
      tbl[5] = '{en:0, se:0, si:1, a1:4'b1111, a2:4'b1111, b1:0, b2:0, c:4'b1111, zn:4'b1000, so:1};
      tbl[6] = '{en:1, se:1, si:0, a1:4'b1111, a2:4'b1111, b1:0, b2:0, c:0, zn:4'b0000, so:0};
      tbl[7] = '{en:1, se:0, si:0, a1:0, a2:0, b1:4'b1111, b2:0, c:0, zn:4'b1111, so:1};
      tbl[8] = '{en:0, se:0, si:0, a1:4'b1111, a2:4'b1111, b1:0, b2:0, c:0, zn:4'b1111, so:1};

      RST = 1'b1; BIST_START = 1'b0; BIST_FI = 1'b0;
      set_in(0, 0, 0, '0, '0, '0, '0, '0);
      step();
      step();
      chk4("rst_zn", ZN, 4'b0000);
      chk1("rst_so", SO, 1'b0);
      chk1("rst_busy", BIST_BUSY, 1'b0);
      chk1("rst_done", BIST_DONE, 1'b0);
      chk1("rst_pass", BIST_PASS, 1'b0);
      RST = 1'b0;
      step();

      for (int i = 0; i < 9; i++) begin
         set_in(tbl[i].en, tbl[i].se, tbl[i].si, tbl[i].a1, tbl[i].a2, tbl[i].b1, tbl[i].b2, tbl[i].c);
         step();
         chk4($sformatf("tbl%0d_zn", i), ZN, tbl[i].zn);
         chk1($sformatf("tbl%0d_so", i), SO, tbl[i].so);
      end

      // Randomized functional/scan traffic vs. integer model.
      mzn = 15;
      for (int i = 0; i < 200; i++) begin
         set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)));
         if (SE)      nz = ((mzn * 2) + int'(SI)) % 16;
         else if (EN) nz = (~((int'(A1) & int'(A2)) | (int'(B1) & int'(B2)) | int'(C))) & 15;
         else         nz = mzn;
         step();
         mzn = nz;
         chk4($sformatf("rnd%0d_zn", i), ZN, 4'(mzn));
         chk1($sformatf("rnd%0d_so", i), SO, 1'(mzn / 8));
      end

      // Load a known pattern, then start self-test with SE high in the same cycle.
      set_in(1, 0, 0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000);
      step();
      chk4("preload_zn", ZN, 4'b0101);
      zbefore = 4'b0101;
      EN = 1'b0;
      run_bist("bist_pass", 1'b0, 1'b1, 1'b0, 1'b1, zbefore);

      // Fault injection, restarted from DONE.
      run_bist("bist_fault", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);

      // Reset in the middle of a run.
      BIST_START = 1'b1;
      step();
      BIST_START = 1'b0;
      for (int i = 0; i < 9; i++) step();
      chk1("mid_busy_before_rst", BIST_BUSY, 1'b1);
      RST = 1'b1;
      #1;
      chk4("mid_rst_zn", ZN, 4'b0000);
      chk1("mid_rst_so", SO, 1'b0);
      chk1("mid_rst_busy", BIST_BUSY, 1'b0);
      chk1("mid_rst_done", BIST_DONE, 1'b0);
      chk1("mid_rst_pass", BIST_PASS, 1'b0);
      step();
      RST = 1'b0;
      step();
      run_bist("bist_after_rst", 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);

      // START/SE/EN activity during the run must not disturb it.
      run_bist("bist_disturb", 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);

      // Functional path works again after self-test.
      set_in(1, 0, 0, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0100);
      step();
      chk4("post_bist_load", ZN, 4'b1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
